// File: rtl/buscaminas_button_pulser.sv
// Push-button front end: two-flop synchronizer, debouncer, press-edge pulser and
// flag/select conflict filter. Define BUSCAMINAS_AUTO_REPEAT_EN for held-move auto-repeat.
module buscaminas_button_pulser #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    input  logic       lock,
    output logic       btn_up_down,
    output logic       btn_left_right,
    output logic       btn_flag,
    output logic       btn_select,
    output logic [3:0] pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_meta_r;
    logic [3:0]       sync_r;
    logic [CNT_W-1:0] db_cnt_r [4];
    logic [3:0]       pressed_r;
    logic [3:0]       pressed_d_r;
    logic [3:0]       pulse_r;
    logic [3:0]       rise_s;
    logic [3:0]       fire_s;
    logic [1:0]       rep_fire_s;

    // Synchronizer; the inversion is taken at the input so reset (0) means released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 4'b0000;
            sync_r      <= 4'b0000;
        end else begin
            sync_meta_r <= ~key_n;
            sync_r      <= sync_meta_r;
        end
    end

    // Debouncer: count consecutive cycles of disagreement, accept after DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_r[i] == pressed_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == CNT_LAST) begin
                    db_cnt_r[i]  <= '0;
                    pressed_r[i] <= ~pressed_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Previous debounced level for press-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_d_r <= 4'b0000;
        end else begin
            pressed_d_r <= pressed_r;
        end
    end

    assign rise_s = pressed_r & ~pressed_d_r;

`ifdef BUSCAMINAS_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_r [2];
    logic [1:0]       rep_armed_r;
    logic [1:0]       rep_first_r;

    // Repeat fires when the timer since the last pulse reaches the current interval.
    always_comb begin
        rep_fire_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (rep_first_r[i]) begin
                rep_fire_s[i] = rep_armed_r[i] & pressed_r[i] & (rep_cnt_r[i] == REP_FIRST_LAST);
            end else begin
                rep_fire_s[i] = rep_armed_r[i] & pressed_r[i] & (rep_cnt_r[i] == REP_NEXT_LAST);
            end
        end
    end

    // Repeat timers for the move channels; a release or lock disarms them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_armed_r <= 2'b00;
            rep_first_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rep_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (lock || !pressed_r[i]) begin
                    rep_armed_r[i] <= 1'b0;
                    rep_first_r[i] <= 1'b0;
                    rep_cnt_r[i]   <= '0;
                end else if (fire_s[i]) begin
                    rep_armed_r[i] <= 1'b1;
                    rep_first_r[i] <= rise_s[i];
                    rep_cnt_r[i]   <= '0;
                end else if (rep_armed_r[i]) begin
                    rep_cnt_r[i] <= rep_cnt_r[i] + {{(REP_W-1){1'b0}}, 1'b1};
                end else begin
                    rep_cnt_r[i] <= rep_cnt_r[i];
                end
            end
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign rep_fire_s = 2'b00;
`endif

    // Pulse request: press edges plus repeats, flag/select collision cancels both, lock kills all.
    always_comb begin
        fire_s = 4'b0000;
        if (lock) begin
            fire_s = 4'b0000;
        end else begin
            fire_s = rise_s | {2'b00, rep_fire_s};
            if (fire_s[2] && fire_s[3]) begin
                fire_s[3:2] = 2'b00;
            end else begin
                fire_s[3:2] = fire_s[3:2];
            end
        end
    end

    // Registered one-cycle command pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_r <= 4'b0000;
        end else begin
            pulse_r <= fire_s;
        end
    end

    assign btn_up_down    = pulse_r[0];
    assign btn_left_right = pulse_r[1];
    assign btn_flag       = pulse_r[2];
    assign btn_select     = pulse_r[3];
    assign pressed        = pressed_r;

endmodule

// File: tb/tb_buscaminas_button_pulser.sv
// Bench for buscaminas_button_pulser: windowed debounce model checked every cycle,
// plus directed scenarios with hand-computed latencies and pulse counts.
module tb_buscaminas_button_pulser;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       lock = 1'b0;
    logic       btn_up_down, btn_left_right, btn_flag, btn_select;
    logic [3:0] pressed;

    int total = 0;
    int bad = 0;

    buscaminas_button_pulser #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .lock(lock),
        .btn_up_down(btn_up_down),
        .btn_left_right(btn_left_right),
        .btn_flag(btn_flag),
        .btn_select(btn_select),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Model state: pressed flips once the last DB synchronized samples all disagree with it.
    logic [3:0] ps_hist [DB];
    logic [3:0] raw_prev;
    logic [3:0] m_pressed, m_pressed_d, m_pulse;
    int         mcyc;
    logic [1:0] m_armed;
    int         m_t0 [2];

    task automatic model_clear();
        for (int j = 0; j < DB; j++) ps_hist[j] = 4'b0000;
        raw_prev    = 4'b0000;
        m_pressed   = 4'b0000;
        m_pressed_d = 4'b0000;
        m_pulse     = 4'b0000;
        m_armed     = 2'b00;
        mcyc        = 0;
    endtask

    task automatic model_step();
        logic [3:0] nxt, rise, fire;
        logic       flip;
        int         el;
        mcyc++;
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++) if (ps_hist[j][i] == m_pressed[i]) flip = 1'b0;
            nxt[i] = flip ? ~m_pressed[i] : m_pressed[i];
        end
        rise = m_pressed & ~m_pressed_d;
        fire = rise;
`ifdef BUSCAMINAS_AUTO_REPEAT_EN
        for (int i = 0; i < 2; i++) begin
            el = mcyc - m_t0[i];
            if (m_armed[i] && m_pressed[i] && (el == RD || (el > RD && (el - RD) % RP == 0)))
                fire[i] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (lock || !m_pressed[i]) m_armed[i] = 1'b0;
            else if (rise[i]) begin
                m_armed[i] = 1'b1;
                m_t0[i] = mcyc;
            end
        end
`else
        el = 0;
`endif
        if (fire[2] && fire[3]) fire[3:2] = 2'b00;
        if (lock) fire = 4'b0000;
        m_pulse = fire;
        for (int j = DB - 1; j > 0; j--) ps_hist[j] = ps_hist[j-1];
        ps_hist[0]  = raw_prev;
        raw_prev    = ~key_n;
        m_pressed_d = m_pressed;
        m_pressed   = nxt;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (rst) model_clear();
            else model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("model_pressed", {4'h0, pressed}, {4'h0, m_pressed});
                check("model_pulses", {4'h0, btn_select, btn_flag, btn_left_right, btn_up_down},
                      {4'h0, m_pulse});
            end
        end
    end

    int n_ud = 0, n_lr = 0, n_fl = 0, n_se = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (btn_up_down)    n_ud <= n_ud + 1;
            if (btn_left_right) n_lr <= n_lr + 1;
            if (btn_flag)       n_fl <= n_fl + 1;
            if (btn_select)     n_se <= n_se + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b0, b1, b2, b3;
    int exp_cnt;

    initial begin
        cyc(3);
        check("reset_outputs", {pressed, btn_select, btn_flag, btn_left_right, btn_up_down}, 8'h00);
        #2 rst = 1'b0;

        // Clean press on up/down: key low before edge E.
        cyc(2);
        b0 = n_ud;
        key_n[0] = 1'b0;
        cyc(5);
        check("press_not_yet", {7'h0, pressed[0]}, 8'h00);
        cyc(1);
        check("press_level", {7'h0, pressed[0]}, 8'h01);
        check("press_no_pulse_yet", {7'h0, btn_up_down}, 8'h00);
        cyc(1);
        check("press_pulse", {7'h0, btn_up_down}, 8'h01);
        cyc(1);
        check("press_pulse_end", {7'h0, btn_up_down}, 8'h00);
        cyc(32);
        key_n[0] = 1'b1;
        cyc(12);
`ifdef BUSCAMINAS_AUTO_REPEAT_EN
        exp_cnt = 4;
`else
        exp_cnt = 1;
`endif
        check("press_count", 8'(n_ud - b0), 8'(exp_cnt));
        check("release_level", {4'h0, pressed}, 8'h00);

        // Bounce on flag: 2-cycle glitches never reach the debounce threshold.
        b2 = n_fl;
        for (int k = 0; k < 10; k++) begin
            key_n[2] = ~key_n[2];
            cyc(2);
        end
        key_n[2] = 1'b1;
        cyc(10);
        check("bounce_level", {7'h0, pressed[2]}, 8'h00);
        check("bounce_count", 8'(n_fl - b2), 8'h00);

        // Flag and select together cancel each other.
        b2 = n_fl; b3 = n_se;
        key_n[3:2] = 2'b00;
        cyc(15);
        check("conflict_level", {4'h0, pressed}, 8'h0C);
        check("conflict_flag", 8'(n_fl - b2), 8'h00);
        check("conflict_select", 8'(n_se - b3), 8'h00);
        key_n[3:2] = 2'b11;
        cyc(12);
        b2 = n_fl; b3 = n_se;
        key_n[2] = 1'b0;
        cyc(1);
        key_n[3] = 1'b0;
        cyc(15);
        check("offset_flag", 8'(n_fl - b2), 8'h01);
        check("offset_select", 8'(n_se - b3), 8'h01);
        key_n[3:2] = 2'b11;
        cyc(12);

        // Lock swallows a press edge; dropping lock while held does not pulse.
        b1 = n_lr;
        lock = 1'b1;
        key_n[1] = 1'b0;
        cyc(15);
        check("lock_level", {7'h0, pressed[1]}, 8'h01);
        lock = 1'b0;
        cyc(10);
        check("lock_count", 8'(n_lr - b1), 8'h00);
        key_n[1] = 1'b1;
        cyc(12);
        key_n[1] = 1'b0;
        cyc(12);
        key_n[1] = 1'b1;
        cyc(12);
        check("unlock_count", 8'(n_lr - b1), 8'h01);

        // Reset in the middle of a debounce count, key still held afterwards.
        key_n[0] = 1'b0;
        cyc(4);
        #2 rst = 1'b1;
        #1 check("reset_mid", {pressed, btn_select, btn_flag, btn_left_right, btn_up_down}, 8'h00);
        cyc(2);
        #2 rst = 1'b0;
        b0 = n_ud;
        cyc(5);
        check("rst_press_not_yet", {7'h0, pressed[0]}, 8'h00);
        cyc(1);
        check("rst_press_level", {7'h0, pressed[0]}, 8'h01);
        cyc(1);
        check("rst_press_pulse", {7'h0, btn_up_down}, 8'h01);
        cyc(10);
        key_n[0] = 1'b1;
        cyc(12);
        check("rst_press_count", 8'(n_ud - b0), 8'h01);

`ifdef BUSCAMINAS_AUTO_REPEAT_EN
        // Held move repeats at T, T+20, T+28, ...; held select does not.
        b0 = n_ud; b3 = n_se;
        key_n[0] = 1'b0;
        cyc(60);
        key_n[0] = 1'b1;
        cyc(12);
        check("repeat_count", 8'(n_ud - b0), 8'h06);
        key_n[3] = 1'b0;
        cyc(40);
        key_n[3] = 1'b1;
        cyc(12);
        check("select_no_repeat", 8'(n_se - b3), 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
